// File: rtl/imul_iterative_rtl.sv
// imul_iterative_rtl: iterative shift-add multiplier producing the low p_nbits of a*b
// over a val/rdy stream, one multiply in flight, fixed latency of p_nbits+1 cycles.
module imul_iterative_rtl #(
   parameter int p_nbits = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   istream_val,
   output logic                   istream_rdy,
   input  logic [2*p_nbits-1:0]   istream_msg,
   output logic                   ostream_val,
   input  logic                   ostream_rdy,
   output logic [p_nbits-1:0]     ostream_msg
);
   localparam int cw = $clog2(p_nbits) + 1;
   localparam logic [cw-1:0] last = cw'(p_nbits - 1);
   localparam logic [cw-1:0] one = cw'(1);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_next;
   logic [p_nbits-1:0] a_reg, b_reg, result_reg;
   logic [cw-1:0] count;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else state <= state_next;
   end
   always_comb begin
      state_next = state;
      istream_rdy = 1'b0;
      ostream_val = 1'b0;
      ostream_msg = '0;
      case (state)
         IDLE: begin
            istream_rdy = !rst;
            if (istream_val) state_next = CALC;
         end
         CALC: if (count == last) state_next = DONE;
         DONE: begin
            ostream_val = 1'b1;
            ostream_msg = result_reg;
            if (ostream_rdy) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end
   // Operands are only captured on the IDLE accept; CALC shifts them in place.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg <= '0;
         b_reg <= '0;
         result_reg <= '0;
         count <= '0;
      end else if (state == IDLE && istream_val) begin
         a_reg <= istream_msg[2*p_nbits-1:p_nbits];
         b_reg <= istream_msg[p_nbits-1:0];
         result_reg <= '0;
         count <= '0;
      end else if (state == CALC) begin
         if (b_reg[0]) result_reg <= result_reg + a_reg;
         a_reg <= a_reg << 1;
         b_reg <= b_reg >> 1;
         count <= count + one;
      end
   end
endmodule
